// File: rtl/seq_alu.sv
// Registered ALU with start/done handshake and iterative shift-add multiply.
// Ports: Clock/Resetn, Start/Inst/A/BusWires in; Busy/Done/Result/ResultHi/flags out.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [3:0]       Inst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] BusWires,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Zero,
  output logic             Carry,
  output logic             Overflow,
  output logic             Illegal
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] mcand, mcand_n;
  logic [2*WIDTH-1:0] acc, acc_n;

  logic             done_n;
  logic [WIDTH-1:0] res_n, hi_n;
  logic             z_n, c_n, v_n, ill_n;

  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_ill;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_step;

  assign add_w = {1'b0, A} + {1'b0, BusWires};
  assign sub_w = {1'b0, A} - {1'b0, BusWires};

  // acc holds {partial product, remaining multiplier bits}; the sum's
  // carry shifts back into the top as the whole accumulator moves right.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, mcand} : '0);
  assign acc_step = {mul_sum, acc[WIDTH-1:1]};

  assign Busy = (state == MUL);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    unique case (Inst)
      4'b0010: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (A[WIDTH-1] == BusWires[WIDTH-1])
               && (add_w[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0011: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (A[WIDTH-1] != BusWires[WIDTH-1])
               && (sub_w[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0100: alu_res = A & BusWires;
      4'b0101: alu_res = ~(A & BusWires);
      4'b0110: alu_res = A | BusWires;
      4'b0111: alu_res = ~(A | BusWires);
      4'b1010: begin
        alu_res = {A[0], A[WIDTH-1:1]};
        alu_c   = A[0];
      end
      4'b1011: begin
        alu_res = {A[WIDTH-2:0], A[WIDTH-1]};
        alu_c   = A[WIDTH-1];
      end
      4'b1100: alu_res = ~A;
      4'b1101: begin
        alu_res = {A[WIDTH-2:0], 1'b0};
        alu_c   = A[WIDTH-1];
      end
      4'b1110: begin
        alu_res = {1'b0, A[WIDTH-1:1]};
        alu_c   = A[0];
      end
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mcand_n = mcand;
    acc_n   = acc;
    done_n  = 1'b0;
    res_n   = Result;
    hi_n    = ResultHi;
    z_n     = Zero;
    c_n     = Carry;
    v_n     = Overflow;
    ill_n   = Illegal;
    unique case (state)
      IDLE: begin
        if (Start) begin
          if (Inst == 4'b0000) begin
            state_n = MUL;
            mcand_n = A;
            acc_n   = {{WIDTH{1'b0}}, BusWires};
            cnt_n   = CW'(WIDTH);
          end else begin
            done_n = 1'b1;
            res_n  = alu_res;
            hi_n   = '0;
            z_n    = !alu_ill && (alu_res == '0);
            c_n    = alu_c;
            v_n    = alu_v;
            ill_n  = alu_ill;
          end
        end
      end
      MUL: begin
        acc_n = acc_step;
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
          res_n   = acc_step[WIDTH-1:0];
          hi_n    = acc_step[2*WIDTH-1:WIDTH];
          z_n     = (acc_step == '0);
          c_n     = (acc_step[2*WIDTH-1:WIDTH] != '0);
          v_n     = 1'b0;
          ill_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      mcand    <= '0;
      acc      <= '0;
      Done     <= 1'b0;
      Result   <= '0;
      ResultHi <= '0;
      Zero     <= 1'b0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
      Illegal  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      mcand    <= mcand_n;
      acc      <= acc_n;
      Done     <= done_n;
      Result   <= res_n;
      ResultHi <= hi_n;
      Zero     <= z_n;
      Carry    <= c_n;
      Overflow <= v_n;
      Illegal  <= ill_n;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: WIDTH=8 and WIDTH=16 instances against an
// arithmetic reference model, directed plan cases plus random streams.
module tb_seq_alu;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] hi;
    logic        z;
    logic        c;
    logic        v;
    logic        ill;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        s8 = 1'b0;
  logic [3:0]  i8 = 4'h0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        bz8, dn8, z8, c8, v8, il8;
  logic [7:0]  r8, h8;

  logic        s16 = 1'b0;
  logic [3:0]  i16 = 4'h0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        bz16, dn16, z16, c16, v16, il16;
  logic [15:0] r16, h16;

  int vec = 0;
  int bad = 0;

  logic [3:0] nm_ops [13] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA,
                              4'hB, 4'hC, 4'hD, 4'hE, 4'h1, 4'hF};

  seq_alu #(.WIDTH(8)) u8 (
    .Clock(clk), .Resetn(rst_n), .Start(s8), .Inst(i8),
    .A(a8), .BusWires(b8), .Busy(bz8), .Done(dn8),
    .Result(r8), .ResultHi(h8), .Zero(z8), .Carry(c8),
    .Overflow(v8), .Illegal(il8)
  );

  seq_alu #(.WIDTH(16)) u16 (
    .Clock(clk), .Resetn(rst_n), .Start(s16), .Inst(i16),
    .A(a16), .BusWires(b16), .Busy(bz16), .Done(dn16),
    .Result(r16), .ResultHi(h16), .Zero(z16), .Carry(c16),
    .Overflow(v16), .Illegal(il16)
  );

  function automatic logic bitof(input logic [63:0] x, input int n);
    return x[n];
  endfunction

  function automatic res_t model(input int w, input logic [3:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    res_t o;
    logic [63:0] m, x, y, p;
    o = '0;
    m = (64'd1 << w) - 64'd1;
    x = {32'd0, a} & m;
    y = {32'd0, b} & m;
    p = '0;
    case (op)
      4'h0: begin
        p = x * y;
        o.hi = 32'((p >> w) & m);
        o.z = (p == 0);
        o.c = (o.hi != 0);
      end
      4'h2: begin
        p = x + y;
        o.c = bitof(p, w);
        o.v = (bitof(x, w-1) == bitof(y, w-1))
           && (bitof(p, w-1) != bitof(x, w-1));
      end
      4'h3: begin
        p = x - y;
        o.c = (x < y);
        o.v = (bitof(x, w-1) != bitof(y, w-1))
           && (bitof(p, w-1) != bitof(x, w-1));
      end
      4'h4: p = x & y;
      4'h5: p = ~(x & y);
      4'h6: p = x | y;
      4'h7: p = ~(x | y);
      4'hA: begin
        p = (x >> 1) | ((x & 64'd1) << (w - 1));
        o.c = bitof(x, 0);
      end
      4'hB: begin
        p = (x << 1) | (x >> (w - 1));
        o.c = bitof(x, w-1);
      end
      4'hC: p = ~x;
      4'hD: begin
        p = x << 1;
        o.c = bitof(x, w-1);
      end
      4'hE: begin
        p = x >> 1;
        o.c = bitof(x, 0);
      end
      default: o.ill = 1'b1;
    endcase
    if (!o.ill) o.r = 32'(p & m);
    if (op != 4'h0 && !o.ill) o.z = ((p & m) == 0);
    return o;
  endfunction

  function automatic res_t obs(input int w);
    res_t o;
    o = '0;
    if (w == 8) begin
      o.r = {24'd0, r8};
      o.hi = {24'd0, h8};
      o.z = z8; o.c = c8; o.v = v8; o.ill = il8;
    end else begin
      o.r = {16'd0, r16};
      o.hi = {16'd0, h16};
      o.z = z16; o.c = c16; o.v = v16; o.ill = il16;
    end
    return o;
  endfunction

  // Issues one request and waits (bounded) for Done; lat counts edges
  // after the accept edge, busy0 is Busy just after the accept edge.
  task automatic issue(input int w, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       output res_t o, output int lat,
                       output logic busy0);
    @(negedge clk);
    if (w == 8) begin
      s8 = 1'b1; i8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      s16 = 1'b1; i16 = op; a16 = a[15:0]; b16 = b[15:0];
    end
    @(posedge clk); #1;
    s8 = 1'b0;
    s16 = 1'b0;
    lat = 0;
    busy0 = (w == 8) ? bz8 : bz16;
    while (((w == 8) ? dn8 : dn16) !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    o = obs(w);
  endtask

  task automatic test_reset();
    res_t o;
    int lat;
    logic b0;
    #1 rst_n = 1'b0;
    #1;
    vec++;
    if (obs(8) !== '0 || obs(16) !== '0 || {bz8, dn8, bz16, dn16} !== 4'b0) begin
      bad++;
      $display("FAIL reset_init: got r=%h busy=%b done=%b, want all 0",
               r8, bz8, dn8);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    issue(8, 4'h2, 32'h22, 32'h33, o, lat, b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if (obs(8) !== '0 || dn8 !== 1'b0 || bz8 !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: got r=%h done=%b busy=%b, want 0 0 0",
               r8, dn8, bz8);
    end
    @(negedge clk) rst_n = 1'b1;
    issue(8, 4'h2, 32'h11, 32'h01, o, lat, b0);
    vec++;
    if (o.r !== 32'h12 || o.c !== 1'b0 || lat != 0 || b0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_add: got r=%h c=%b lat=%0d busy=%b, want 12 0 0 0",
               o.r, o.c, lat, b0);
    end
    @(posedge clk); #1;
    vec++;
    if (dn8 !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse: got done=%b, want 0", dn8);
    end
  endtask

  task automatic test_addsub();
    logic [3:0]  op_t [3] = '{4'h2, 4'h2, 4'h3};
    logic [31:0] a_t  [3] = '{32'h5F, 32'hFF, 32'h0C};
    logic [31:0] b_t  [3] = '{32'h60, 32'h01, 32'h1C};
    logic [31:0] r_t  [3] = '{32'hBF, 32'h00, 32'hF0};
    logic [2:0]  f_t  [3] = '{3'b001, 3'b110, 3'b010};
    res_t o, e;
    int lat;
    logic b0;
    logic [3:0] op;
    logic [31:0] a, b;
    for (int k = 0; k < 3; k++) begin
      issue(8, op_t[k], a_t[k], b_t[k], o, lat, b0);
      vec++;
      if (o.r !== r_t[k] || {o.z, o.c, o.v} !== f_t[k] || lat != 0) begin
        bad++;
        $display("FAIL addsub_dir%0d: got r=%h zcv=%b%b%b lat=%0d, want r=%h zcv=%b lat=0",
                 k, o.r, o.z, o.c, o.v, lat, r_t[k], f_t[k]);
      end
    end
    for (int k = 0; k < 40; k++) begin
      op = ($urandom_range(0, 1) == 0) ? 4'h2 : 4'h3;
      a = $urandom & 32'hFF;
      b = $urandom & 32'hFF;
      e = model(8, op, a, b);
      issue(8, op, a, b, o, lat, b0);
      vec++;
      if (o !== e || lat != 0 || b0 !== 1'b0) begin
        bad++;
        $display("FAIL addsub_rand: op=%h a=%h b=%h got r=%h zcvi=%b%b%b%b lat=%0d, want r=%h zcvi=%b%b%b%b",
                 op, a, b, o.r, o.z, o.c, o.v, o.ill, lat,
                 e.r, e.z, e.c, e.v, e.ill);
      end
    end
  endtask

  task automatic test_multiply();
    res_t o, e;
    int lat;
    logic b0;
    logic [31:0] a, b;
    issue(8, 4'h0, 32'h10, 32'h20, o, lat, b0);
    vec++;
    if (o.r !== 32'h00 || o.hi !== 32'h02 || o.c !== 1'b1 || o.z !== 1'b0
        || lat != 8 || b0 !== 1'b1 || bz8 !== 1'b0) begin
      bad++;
      $display("FAIL mul_10x20: got lo=%h hi=%h c=%b z=%b lat=%0d, want 00 02 1 0 lat=8",
               o.r, o.hi, o.c, o.z, lat);
    end
    issue(8, 4'h0, 32'hFF, 32'hFF, o, lat, b0);
    vec++;
    if (o.r !== 32'h01 || o.hi !== 32'hFE || o.c !== 1'b1 || lat != 8) begin
      bad++;
      $display("FAIL mul_FFxFF: got lo=%h hi=%h c=%b lat=%0d, want 01 FE 1 8",
               o.r, o.hi, o.c, lat);
    end
    for (int k = 0; k < 20; k++) begin
      a = (k == 0) ? 32'h0 : ($urandom & 32'hFF);
      b = $urandom & 32'hFF;
      e = model(8, 4'h0, a, b);
      issue(8, 4'h0, a, b, o, lat, b0);
      vec++;
      if (o !== e || lat != 8 || b0 !== 1'b1 || bz8 !== 1'b0) begin
        bad++;
        $display("FAIL mul_rand: a=%h b=%h got lo=%h hi=%h zc=%b%b lat=%0d, want lo=%h hi=%h zc=%b%b lat=8",
                 a, b, o.r, o.hi, o.z, o.c, lat, e.r, e.hi, e.z, e.c);
      end
    end
  endtask

  task automatic test_busy_interlock();
    res_t o;
    int ndone, dcyc;
    logic clash;
    o = '0;
    ndone = 0;
    dcyc = 0;
    clash = 1'b0;
    @(negedge clk);
    s8 = 1'b1; i8 = 4'h0; a8 = 8'h10; b8 = 8'h20;
    @(posedge clk); #1;
    s8 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (dn8 === 1'b1) begin
        ndone++;
        dcyc = c;
        o = obs(8);
      end
      if (dn8 === 1'b1 && bz8 === 1'b1) clash = 1'b1;
      if (c == 2) begin
        s8 = 1'b1; i8 = 4'h2;
      end
      if (c == 4) s8 = 1'b0;
      a8 = (c < 4) ? 8'h01 : 8'($urandom);
      b8 = (c < 4) ? 8'h01 : 8'($urandom);
    end
    vec++;
    if (ndone != 1 || dcyc != 8 || o.r !== 32'h00 || o.hi !== 32'h02 || clash) begin
      bad++;
      $display("FAIL busy_interlock: got dones=%0d at=%0d lo=%h hi=%h clash=%b, want 1 8 00 02 0",
               ndone, dcyc, o.r, o.hi, clash);
    end
  endtask

  task automatic test_shift_logic();
    logic [3:0]  op_t [5] = '{4'hA, 4'hB, 4'hE, 4'h5, 4'hC};
    logic [31:0] a_t  [5] = '{32'h1E, 32'h1E, 32'h01, 32'h3F, 32'h4F};
    logic [31:0] b_t  [5] = '{32'h00, 32'h00, 32'h00, 32'h01, 32'h00};
    logic [31:0] r_t  [5] = '{32'h0F, 32'h3C, 32'h00, 32'hFE, 32'hB0};
    logic [1:0]  f_t  [5] = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b00};
    res_t o, e;
    int lat;
    logic b0;
    logic [3:0] op;
    logic [31:0] a, b;
    for (int k = 0; k < 5; k++) begin
      issue(8, op_t[k], a_t[k], b_t[k], o, lat, b0);
      vec++;
      if (o.r !== r_t[k] || {o.z, o.c} !== f_t[k] || o.v !== 1'b0 || lat != 0) begin
        bad++;
        $display("FAIL shlog_dir%0d: got r=%h zc=%b%b lat=%0d, want r=%h zc=%b lat=0",
                 k, o.r, o.z, o.c, lat, r_t[k], f_t[k]);
      end
    end
    for (int k = 0; k < 50; k++) begin
      op = nm_ops[$urandom_range(2, 10)];
      a = $urandom & 32'hFF;
      b = $urandom & 32'hFF;
      e = model(8, op, a, b);
      issue(8, op, a, b, o, lat, b0);
      vec++;
      if (o !== e || lat != 0 || b0 !== 1'b0) begin
        bad++;
        $display("FAIL shlog_rand: op=%h a=%h b=%h got r=%h zcv=%b%b%b, want r=%h zcv=%b%b%b",
                 op, a, b, o.r, o.z, o.c, o.v, e.r, e.z, e.c, e.v);
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] il_t [4] = '{4'h1, 4'h8, 4'h9, 4'hF};
    res_t o, e;
    int lat;
    logic b0;
    logic [31:0] a, b;
    for (int k = 0; k < 4; k++) begin
      issue(8, 4'h2, 32'hFF, 32'h01, o, lat, b0);
      issue(8, il_t[k], $urandom & 32'hFF, $urandom & 32'hFF, o, lat, b0);
      vec++;
      if (o !== 68'h1 || lat != 0 || b0 !== 1'b0) begin
        bad++;
        $display("FAIL illegal_%h: got r=%h hi=%h zcvi=%b%b%b%b lat=%0d, want 0 0 0001 lat=0",
                 il_t[k], o.r, o.hi, o.z, o.c, o.v, o.ill, lat);
      end
      a = $urandom & 32'hFF;
      b = $urandom & 32'hFF;
      e = model(8, 4'h3, a, b);
      issue(8, 4'h3, a, b, o, lat, b0);
      vec++;
      if (o !== e) begin
        bad++;
        $display("FAIL illegal_clear: got r=%h ill=%b, want r=%h ill=0",
                 o.r, o.ill, e.r);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t o, e;
    logic [3:0] op;
    logic [31:0] a, b;
    @(negedge clk);
    op = nm_ops[$urandom_range(0, 12)];
    a = $urandom & 32'hFF;
    b = $urandom & 32'hFF;
    s8 = 1'b1; i8 = op; a8 = a[7:0]; b8 = b[7:0];
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      e = model(8, op, a, b);
      o = obs(8);
      vec++;
      if (o !== e || dn8 !== 1'b1 || bz8 !== 1'b0) begin
        bad++;
        $display("FAIL b2b_%0d: op=%h a=%h b=%h got r=%h zcvi=%b%b%b%b done=%b, want r=%h zcvi=%b%b%b%b done=1",
                 k, op, a, b, o.r, o.z, o.c, o.v, o.ill, dn8,
                 e.r, e.z, e.c, e.v, e.ill);
      end
      op = nm_ops[$urandom_range(0, 12)];
      a = $urandom & 32'hFF;
      b = $urandom & 32'hFF;
      i8 = op; a8 = a[7:0]; b8 = b[7:0];
    end
    s8 = 1'b0;
    @(posedge clk); #1;
    vec++;
    if (dn8 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end: got done=%b, want 0", dn8);
    end
  endtask

  task automatic test_reset_mid_mul();
    int ndone;
    ndone = 0;
    @(negedge clk);
    s8 = 1'b1; i8 = 4'h0; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    s8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vec++;
    if (obs(8) !== '0 || bz8 !== 1'b0 || dn8 !== 1'b0) begin
      bad++;
      $display("FAIL mulreset_outs: got r=%h busy=%b done=%b, want 0 0 0",
               r8, bz8, dn8);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (dn8 === 1'b1 || bz8 === 1'b1) ndone++;
    end
    vec++;
    if (ndone != 0) begin
      bad++;
      $display("FAIL mulreset_nodone: got %0d done/busy cycles, want 0", ndone);
    end
  endtask

  task automatic test_width16();
    res_t o, e;
    int lat;
    logic b0;
    logic [3:0] op;
    logic [31:0] a, b;
    issue(16, 4'h2, 32'h7FFF, 32'h0001, o, lat, b0);
    vec++;
    if (o.r !== 32'h8000 || o.v !== 1'b1 || o.c !== 1'b0 || lat != 0) begin
      bad++;
      $display("FAIL w16_add: got r=%h v=%b c=%b lat=%0d, want 8000 1 0 0",
               o.r, o.v, o.c, lat);
    end
    issue(16, 4'h0, 32'h1234, 32'h0100, o, lat, b0);
    vec++;
    if (o.r !== 32'h3400 || o.hi !== 32'h0012 || o.c !== 1'b1
        || lat != 16 || b0 !== 1'b1) begin
      bad++;
      $display("FAIL w16_mul: got lo=%h hi=%h c=%b lat=%0d, want 3400 0012 1 16",
               o.r, o.hi, o.c, lat);
    end
    for (int k = 0; k < 40; k++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'h0 : nm_ops[$urandom_range(0, 12)];
      a = $urandom & 32'hFFFF;
      b = $urandom & 32'hFFFF;
      e = model(16, op, a, b);
      issue(16, op, a, b, o, lat, b0);
      vec++;
      if (o !== e || lat != ((op == 4'h0) ? 16 : 0)) begin
        bad++;
        $display("FAIL w16_rand: op=%h a=%h b=%h got r=%h hi=%h zcvi=%b%b%b%b lat=%0d, want r=%h hi=%h zcvi=%b%b%b%b",
                 op, a, b, o.r, o.hi, o.z, o.c, o.v, o.ill, lat,
                 e.r, e.hi, e.z, e.c, e.v, e.ill);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_multiply();
    test_busy_interlock();
    test_shift_logic();
    test_illegal();
    test_back_to_back();
    test_reset_mid_mul();
    test_width16();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
